// File: rtl/pe_inst_pkg.sv
// Shared definitions for the per-PE instruction decoder.
// Holds the arbitrated word layout, the sequencing states and the
// packet field positions. Also has a helper that classifies a packet
// as a timestep-0 ifmap location.
package pe_inst_pkg;

  localparam int NODE_W         = 4;
  localparam int CONTENT_W      = 14;
  localparam int PKT_FILTER_BIT = 0;
  localparam int PKT_TS_BIT     = 1;
  localparam int X_LSB          = 2;
  localparam int Y_LSB          = 8;
  localparam int COORD_W        = 6;
  localparam int ROW_W          = 3;
  localparam int MAX_ROWS       = 8;

  typedef struct packed {
    logic [CONTENT_W-1:0] content;
    logic [NODE_W-1:0]    node;
  } inst_word_t;

  // INIT  : collecting filter rows
  // ACK   : offering one ack token upstream
  // READY : waiting for the timestep-0 ifmap of the next set
  // BUSY  : PE working on the current ifmap set
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ACK   = 2'd1,
    READY = 2'd2,
    BUSY  = 2'd3
  } dec_state_t;

  // Timestep-0 ifmap packets have both the filter and timestep bits clear.
  function automatic logic pkt_is_t0(input logic [1:0] pkt_lo);
    return (pkt_lo[PKT_FILTER_BIT] == 1'b0) && (pkt_lo[PKT_TS_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/pe_inst_decoder_ifm_out_reg.sv
// One-entry valid/ready output register for the ifmap location path.
// Ports:
//   clk, rst            clock, async active-high reset
//   load                capture load_x/load_y/load_ts and raise ifm_valid
//   load_x/y/ts         location fields to capture
//   ifm_ready           downstream accepts the held location
//   ifm_valid/x/y/ts    held location toward the PE
// A load in the same cycle the downstream accepts simply overwrites the
// entry, so consecutive locations pass with no bubble.
module pe_inst_decoder_ifm_out_reg
  import pe_inst_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               load_ts,
  input  logic               ifm_ready,
  output logic               ifm_valid,
  output logic [COORD_W-1:0] ifm_x,
  output logic [COORD_W-1:0] ifm_y,
  output logic               ifm_ts
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_valid <= 1'b0;
      ifm_x     <= '0;
      ifm_y     <= '0;
      ifm_ts    <= 1'b0;
    end else if (load) begin
      ifm_valid <= 1'b1;
      ifm_x     <= load_x;
      ifm_y     <= load_y;
      ifm_ts    <= load_ts;
    end else if (ifm_ready) begin
      ifm_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_inst_decoder.sv
// Receive end of the per-PE instruction path.
// Checks the node field of each arbitrated word, turns filter packets
// into row-load strobes, forwards ifmap locations through a one-entry
// register and issues the ack tokens that release each new ifmap set.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready/in_data   arbitrated word {content, pe_node}
//   filt_we/filt_row            one-cycle filter row load strobe
//   ifm_valid/ifm_ready/x/y/ts  ifmap location toward the PE
//   pe_done                     PE finished current ifmap set
//   ack_valid/ack_ready         ack token to the instruction FIFO
//   err_misroute/err_protocol   sticky error flags
module pe_inst_decoder
  import pe_inst_pkg::*;
#(
  parameter int              WIDTH       = 14,
  parameter logic [NODE_W-1:0] PE_NODE   = 4'd0,
  parameter int              FILTER_ROWS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH+NODE_W-1:0] in_data,
  output logic                    filt_we,
  output logic [ROW_W-1:0]        filt_row,
  output logic                    ifm_valid,
  input  logic                    ifm_ready,
  output logic [COORD_W-1:0]      ifm_x,
  output logic [COORD_W-1:0]      ifm_y,
  output logic                    ifm_ts,
  input  logic                    pe_done,
  output logic                    ack_valid,
  input  logic                    ack_ready,
  output logic                    err_misroute,
  output logic                    err_protocol
);

  localparam logic [MAX_ROWS-1:0] FULL_MASK = MAX_ROWS'((1 << FILTER_ROWS) - 1);

  dec_state_t          state, state_nxt;
  logic [MAX_ROWS-1:0] mask, mask_nxt;

  logic [NODE_W-1:0] node;
  logic [WIDTH-1:0]  content;
  logic [ROW_W-1:0]  row;
  logic              xfer, hit, row_ok, filt_ok, filt_bad, ifm_load, t0_load;

  assign node    = in_data[NODE_W-1:0];
  assign content = in_data[WIDTH+NODE_W-1:NODE_W];
  assign row     = content[PKT_FILTER_BIT+1 +: ROW_W];

  // Only the ifmap register can back-pressure; filters never stall.
  assign in_ready = !ifm_valid || ifm_ready;
  assign xfer     = in_valid && in_ready;
  assign hit      = xfer && (node == PE_NODE);
  assign row_ok   = ({1'b0, row} < 4'(FILTER_ROWS));
  assign filt_ok  = hit && content[PKT_FILTER_BIT] && row_ok;
  assign filt_bad = hit && content[PKT_FILTER_BIT] && !row_ok;
  assign ifm_load = hit && !content[PKT_FILTER_BIT];
  assign t0_load  = ifm_load && pkt_is_t0(content[1:0]);

  assign mask_nxt  = filt_ok ? (mask | (MAX_ROWS'(1) << row)) : mask;
  assign ack_valid = (state == ACK);

  always_comb begin
    state_nxt = state;
    case (state)
      // Uses the updated mask so the completing row moves to ACK on its own edge.
      INIT:    if (mask_nxt == FULL_MASK) state_nxt = ACK;
      ACK:     if (ack_ready) state_nxt = READY;
      READY:   if (t0_load) state_nxt = BUSY;
      BUSY:    if (pe_done) state_nxt = ACK;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      mask         <= '0;
      filt_we      <= 1'b0;
      filt_row     <= '0;
      err_misroute <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      state   <= state_nxt;
      mask    <= mask_nxt;
      filt_we <= filt_ok;
      if (filt_ok) filt_row <= row;
      if (xfer && !hit) err_misroute <= 1'b1;
      if (filt_bad || (t0_load && state != READY)) err_protocol <= 1'b1;
    end
  end

  pe_inst_decoder_ifm_out_reg u_ifm_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifm_load),
    .load_x    (content[X_LSB +: COORD_W]),
    .load_y    (content[Y_LSB +: COORD_W]),
    .load_ts   (content[PKT_TS_BIT]),
    .ifm_ready (ifm_ready),
    .ifm_valid (ifm_valid),
    .ifm_x     (ifm_x),
    .ifm_y     (ifm_y),
    .ifm_ts    (ifm_ts)
  );

endmodule

// File: tb/tb_pe_inst_decoder.sv
// Bench for pe_inst_decoder with WIDTH=14, PE_NODE=0, FILTER_ROWS=5.
module tb_pe_inst_decoder;
  import pe_inst_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_data = '0;
  logic        filt_we;
  logic [2:0]  filt_row;
  logic        ifm_valid;
  logic        ifm_ready = 1'b1;
  logic [5:0]  ifm_x, ifm_y;
  logic        ifm_ts;
  logic        pe_done = 1'b0;
  logic        ack_valid;
  logic        ack_ready = 1'b0;
  logic        err_misroute, err_protocol;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: rows seen, which phase of the set cycle we are in,
  // and the expected registered outputs.
  bit       m_rows[8];
  bit       m_collect, m_need_ack, m_armed, m_busy;
  bit       m_filt_we, m_ifm_valid, m_ts, m_err_mis, m_err_prot;
  bit [2:0] m_filt_row;
  bit [5:0] m_x, m_y;

  pe_inst_decoder #(.WIDTH(14), .PE_NODE(4'd0), .FILTER_ROWS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .filt_we(filt_we), .filt_row(filt_row),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_x(ifm_x),
    .ifm_y(ifm_y), .ifm_ts(ifm_ts), .pe_done(pe_done),
    .ack_valid(ack_valid), .ack_ready(ack_ready),
    .err_misroute(err_misroute), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [3:0] node, input logic [13:0] c);
    inst_word_t w;
    w.content = c;
    w.node    = node;
    return w;
  endfunction

  function automatic logic [13:0] filt_pkt(input int r);
    return 14'((r << 1) | 1);
  endfunction

  function automatic logic [13:0] ifm_pkt(input int y, input int x, input int ts);
    return 14'((y << 8) | (x << 2) | (ts << 1));
  endfunction

  task automatic model_reset();
    foreach (m_rows[i]) m_rows[i] = 1'b0;
    m_collect = 1; m_need_ack = 0; m_armed = 0; m_busy = 0;
    m_filt_we = 0; m_ifm_valid = 0; m_ts = 0; m_err_mis = 0; m_err_prot = 0;
    m_filt_row = 0; m_x = 0; m_y = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then return 1ns after the edge.
  task automatic tick();
    bit xr, hit, ld, t0, all_rows;
    logic [13:0] c;
    int r;
    xr  = in_valid && (!m_ifm_valid || ifm_ready);
    c   = in_data[17:4];
    hit = xr && (in_data[3:0] == 4'd0);
    @(posedge clk);
    m_filt_we = 0; ld = 0; t0 = 0;
    if (xr && !hit) m_err_mis = 1;
    if (hit && c[0]) begin
      r = int'(c[3:1]);
      if (r >= 5) m_err_prot = 1;
      else begin m_filt_we = 1; m_filt_row = c[3:1]; m_rows[r] = 1; end
    end
    if (hit && !c[0]) begin ld = 1; t0 = !c[1]; end
    if (ld) begin m_ifm_valid = 1; m_x = c[7:2]; m_y = c[13:8]; m_ts = c[1]; end
    else if (ifm_ready) m_ifm_valid = 0;
    if (t0 && !m_armed) m_err_prot = 1;
    all_rows = 1;
    for (int k = 0; k < 5; k++) if (!m_rows[k]) all_rows = 0;
    if (m_collect) begin
      if (all_rows) begin m_collect = 0; m_need_ack = 1; end
    end else if (m_need_ack) begin
      if (ack_ready) begin m_need_ack = 0; m_armed = 1; end
    end else if (m_armed) begin
      if (t0) begin m_armed = 0; m_busy = 1; end
    end else if (m_busy) begin
      if (pe_done) begin m_busy = 0; m_need_ack = 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({filt_we, filt_row, ifm_valid, ifm_x, ifm_y, ifm_ts, ack_valid, err_misroute, err_protocol} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %0h want 0",
               {filt_we, filt_row, ifm_valid, ifm_x, ifm_y, ifm_ts, ack_valid, err_misroute, err_protocol});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_filter_fill();
    for (int r = 0; r < 5; r++) begin
      in_valid = 1; in_data = mk(4'd0, filt_pkt(r));
      tick();
      n_cmp++;
      if (filt_we !== 1'b1 || filt_row !== 3'(r)) begin
        n_bad++; $display("FAIL fill_strobe row %0d: got we=%b row=%0d want we=1 row=%0d", r, filt_we, filt_row, r);
      end
      n_cmp++;
      if (ack_valid !== (r == 4)) begin
        n_bad++; $display("FAIL fill_ack row %0d: got %b want %b", r, ack_valid, (r == 4));
      end
    end
    in_valid = 0;
    tick();
    n_cmp++;
    if (filt_we !== 1'b0 || ack_valid !== 1'b1) begin
      n_bad++; $display("FAIL fill_hold: got we=%b ack=%b want we=0 ack=1", filt_we, ack_valid);
    end
    ack_ready = 1;
    tick();
    ack_ready = 0;
    n_cmp++;
    if (ack_valid !== 1'b0) begin n_bad++; $display("FAIL single_token: got ack=%b want 0", ack_valid); end
  endtask

  task automatic test_ifmap_t0();
    ifm_ready = 1; in_valid = 1; in_data = mk(4'd0, ifm_pkt(3, 5, 0));
    tick();
    in_valid = 0;
    n_cmp++;
    if (ifm_valid !== 1'b1 || ifm_x !== 6'd5 || ifm_y !== 6'd3 || ifm_ts !== 1'b0 || err_protocol !== 1'b0) begin
      n_bad++; $display("FAIL t0_fwd: got v=%b x=%0d y=%0d ts=%b ep=%b want v=1 x=5 y=3 ts=0 ep=0",
                        ifm_valid, ifm_x, ifm_y, ifm_ts, err_protocol);
    end
    tick();
    n_cmp++;
    if (ifm_valid !== 1'b0 || ack_valid !== 1'b0) begin
      n_bad++; $display("FAIL busy_idle: got v=%b ack=%b want 0 0", ifm_valid, ack_valid);
    end
    pe_done = 1;
    tick();
    pe_done = 0;
    n_cmp++;
    if (ack_valid !== 1'b1) begin n_bad++; $display("FAIL done_ack: got %b want 1", ack_valid); end
    ack_ready = 1;
    tick();
    ack_ready = 0;
    n_cmp++;
    if (ack_valid !== 1'b0) begin n_bad++; $display("FAIL done_ack_taken: got %b want 0", ack_valid); end
  endtask

  task automatic test_back_to_back();
    ifm_ready = 0; in_valid = 1; in_data = mk(4'd0, ifm_pkt(2, 1, 1));
    tick();
    in_data = mk(4'd0, ifm_pkt(9, 8, 1));
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++;
    if (ifm_valid !== 1'b1 || ifm_x !== 6'd1 || ifm_y !== 6'd2 || ifm_ts !== 1'b1) begin
      n_bad++; $display("FAIL stall_hold: got v=%b x=%0d y=%0d want v=1 x=1 y=2", ifm_valid, ifm_x, ifm_y);
    end
    ifm_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++;
    if (ifm_valid !== 1'b1 || ifm_x !== 6'd8 || ifm_y !== 6'd9) begin
      n_bad++; $display("FAIL no_bubble: got v=%b x=%0d y=%0d want v=1 x=8 y=9", ifm_valid, ifm_x, ifm_y);
    end
    tick();
    n_cmp++;
    if (ifm_valid !== 1'b0) begin n_bad++; $display("FAIL drain: got %b want 0", ifm_valid); end
  endtask

  task automatic test_errors();
    in_valid = 1; in_data = mk(4'd7, filt_pkt(0));
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL misroute_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_cmp++;
    if (filt_we !== 1'b0 || ifm_valid !== 1'b0 || err_misroute !== 1'b1) begin
      n_bad++; $display("FAIL misroute: got we=%b v=%b em=%b want 0 0 1", filt_we, ifm_valid, err_misroute);
    end
    repeat (3) tick();
    n_cmp++;
    if (err_misroute !== 1'b1) begin n_bad++; $display("FAIL misroute_sticky: got %b want 1", err_misroute); end
    in_valid = 1; in_data = mk(4'd0, filt_pkt(6));
    tick();
    in_valid = 0;
    n_cmp++;
    if (filt_we !== 1'b0 || err_protocol !== 1'b1) begin
      n_bad++; $display("FAIL bad_row: got we=%b ep=%b want 0 1", filt_we, err_protocol);
    end
  endtask

  task automatic test_init_t0();
    do_reset();
    in_valid = 1; in_data = mk(4'd0, ifm_pkt(1, 2, 0));
    tick();
    n_cmp++;
    if (ifm_valid !== 1'b1 || err_protocol !== 1'b1 || ack_valid !== 1'b0) begin
      n_bad++; $display("FAIL init_t0: got v=%b ep=%b ack=%b want 1 1 0", ifm_valid, err_protocol, ack_valid);
    end
    for (int r = 0; r < 5; r++) begin
      in_data = mk(4'd0, filt_pkt(r));
      tick();
      n_cmp++;
      if (ack_valid !== (r == 4)) begin
        n_bad++; $display("FAIL init_fill row %0d: got %b want %b", r, ack_valid, (r == 4));
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset_in_ack();
    ifm_ready = 0; in_valid = 1; in_data = mk(4'd0, ifm_pkt(4, 4, 1));
    tick();
    in_valid = 0;
    n_cmp++;
    if (ack_valid !== 1'b1 || ifm_valid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: got ack=%b v=%b want 1 1", ack_valid, ifm_valid);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (ack_valid !== 1'b0 || ifm_valid !== 1'b0 || err_protocol !== 1'b0 || err_misroute !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got ack=%b v=%b ep=%b em=%b want 0 0 0 0",
                        ack_valid, ifm_valid, err_protocol, err_misroute);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    ifm_ready = 1;
    for (int r = 0; r < 5; r++) begin
      in_valid = 1; in_data = mk(4'd0, filt_pkt(r));
      tick();
      n_cmp++;
      if (ack_valid !== (r == 4)) begin
        n_bad++; $display("FAIL refill row %0d: got %b want %b", r, ack_valid, (r == 4));
      end
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    logic [3:0]  node;
    logic [13:0] c;
    int sel;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset();
      sel  = $urandom_range(0, 9);
      node = ($urandom_range(0, 15) == 0) ? 4'd7 : 4'd0;
      if (sel < 4)
        c = filt_pkt(($urandom_range(0, 39) == 0) ? 6 : $urandom_range(0, 4));
      else
        c = ifm_pkt($urandom_range(0, 63), $urandom_range(0, 63), (sel < 7) ? 1 : 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = mk(node, c);
      ifm_ready = ($urandom_range(0, 3) != 0);
      ack_ready = ($urandom_range(0, 1) != 0);
      pe_done   = ($urandom_range(0, 4) == 0);
      #1;
      n_cmp++;
      if (in_ready !== (!m_ifm_valid || ifm_ready)) begin
        n_bad++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, in_ready, (!m_ifm_valid || ifm_ready));
      end
      tick();
      n_cmp++;
      if ({filt_we, filt_row, ifm_valid, ifm_x, ifm_y, ifm_ts, ack_valid, err_misroute, err_protocol} !==
          {m_filt_we, m_filt_row, m_ifm_valid, m_x, m_y, m_ts, m_need_ack, m_err_mis, m_err_prot}) begin
        n_bad++;
        $display("FAIL rand_outputs cyc %0d: got %0h want %0h", i,
                 {filt_we, filt_row, ifm_valid, ifm_x, ifm_y, ifm_ts, ack_valid, err_misroute, err_protocol},
                 {m_filt_we, m_filt_row, m_ifm_valid, m_x, m_y, m_ts, m_need_ack, m_err_mis, m_err_prot});
      end
    end
    in_valid = 0; pe_done = 0; ack_ready = 0; ifm_ready = 1;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_filter_fill();
    test_ifmap_t0();
    test_back_to_back();
    test_errors();
    test_init_t0();
    test_reset_in_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_inst_decoder.md
Name: pe_inst_decoder

Overview:
- Receive end of the per-PE instruction path.
- Consumes arbitrated words {FIFO_content[WIDTH-1:0], PE_node[3:0]}.
- Checks the PE_node field, then decodes filter-row and ifmap-location packets into PE-side strobes.
- Generates the ack tokens that release each new ifmap set (timestep-0 ifmap packet) from the upstream instruction FIFO.
- Clocked block: one clock, asynchronous active-high reset, valid/ready handshakes on every channel.

Parameters:
- WIDTH, 14, FIFO_content width.
- PE_NODE, 4'd0, node ID this decoder answers to.
- FILTER_ROWS, 5, filter rows required before the first ack (1..8).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  arbitrated word valid.
- in_ready  out  1  decoder accepts word this cycle.
- in_data  in  WIDTH+4  {content[WIDTH-1:0], pe_node[3:0]}.
- filt_we  out  1  one-cycle filter-row load strobe.
- filt_row  out  3  filter row index (content[3:1]).
- ifm_valid  out  1  ifmap location valid.
- ifm_ready  in  1  PE accepts ifmap location.
- ifm_x  out  6  content[7:2].
- ifm_y  out  6  content[13:8].
- ifm_ts  out  1  content[1].
- pe_done  in  1  PE finished the current ifmap set (one-cycle pulse).
- ack_valid  out  1  ack token to the instruction FIFO.
- ack_ready  in  1  FIFO takes ack.
- err_misroute  out  1  sticky; pe_node field != PE_NODE seen.
- err_protocol  out  1  sticky; illegal row index or unsolicited timestep-0 packet.

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of state or in-flight handshake:
  - state=INIT, row mask=0.
  - filt_we, ifm_valid, ack_valid, err_* all 0.
  - ifm_x/ifm_y/ifm_ts/filt_row = 0.
  - In-flight words and acks are discarded, not replayed.
- Packet decode:
  - content[0]=1: filter packet.
  - content[1:0]=00: ifmap timestep 0.
  - content[1:0]=10: ifmap timestep 1.
- in_ready = !ifm_valid | ifm_ready, in every state.
  - The decoder never stalls on the filter path or on state.
  - A word transfers when in_valid & in_ready at a rising edge.
- Misroute: pe_node != PE_NODE → word consumed and dropped, err_misroute set; no state change.
- Filter packet, any state:
  - filt_we=1 and filt_row=content[3:1] in the cycle after the transfer (latency 1), for exactly 1 cycle.
  - Row >= FILTER_ROWS → no strobe, err_protocol set.
  - Otherwise mask[row] is set; a duplicate row strobes again and leaves the mask unchanged.
- Ifmap packet: ifm_valid/ifm_x/ifm_y/ifm_ts are registered, so valid rises 1 cycle after the transfer and holds stable until ifm_valid & ifm_ready.
  - If a new word transfers in the same cycle ifm_ready accepts the old one, the register reloads (back-to-back, no bubble).
- FSM, states INIT, ACK, READY, BUSY:
  - INIT: when the mask equals all FILTER_ROWS bits, go to ACK. The row completing the mask goes to ACK at that same edge.
  - ACK: ack_valid=1. On ack_ready, go to READY and drop ack_valid next cycle. Exactly one token per ACK visit.
  - READY: a transferred timestep-0 ifmap goes to BUSY.
  - BUSY: pe_done goes to ACK.
  - Timestep-1 ifmap and filter packets are forwarded in any state with no transition.
- Timestep-0 ifmap in INIT, ACK or BUSY: forwarded anyway, err_protocol set, FSM unchanged.
- pe_done outside BUSY is ignored.
- pe_done and a timestep-0 transfer in the same cycle while READY: the timestep-0 transfer wins (go to BUSY). The pe_done is lost.
- err_* clear only on rst.

Decomposition:
- Shared package pe_inst_pkg:
  - typedef inst_word_t (content + node).
  - enum dec_state_t {INIT, ACK, READY, BUSY}.
  - Constants PKT_FILTER_BIT=0, PKT_TS_BIT=1, X_LSB=2, Y_LSB=8, NODE_W=4.
  - Function pkt_is_t0().
- Natural sub-module: ifm_out_reg, the one-entry valid/ready output register for the ifmap path.
- FSM and decode stay in the top.

Test Plan:
- FILTER_ROWS=5; send filter rows 0..4 to node 0 → five filt_we pulses, rows 0..4. ack_valid rises the cycle after row 4. Hold ack_ready=1 one cycle → exactly one token.
- After the ack, send ifmap {y=3,x=5,ts=0} → ifm_valid 1 cycle later with x=5,y=3,ts=0, state BUSY. Pulse pe_done → ack_valid next cycle.
- Hold ifm_ready=0, send two ifmap ts=1 words → first held stable, in_ready=0. Raise ifm_ready → second loads the same edge, no bubble.
- Send a word with pe_node=4'd7 while PE_NODE=0 → consumed, no strobes, err_misroute=1 persists. Send filter row 6 → err_protocol=1, no filt_we.
- Send timestep-0 ifmap while in INIT → forwarded, err_protocol=1, state stays INIT.
- Assert rst while in ACK with ack_valid=1 → ack_valid=0 and ifm_valid=0 immediately, state INIT, mask cleared. All rows are needed again before the next ack.
